mem_arbiter: RTL

Arbitrates the single-port word RAM between three requesters: the flash loader, the data (load/store) port and the instruction-fetch port. It sits between `controller`/`datapath` and the RAM macro. It grants one access per cycle using fixed priority, with fetch starvation protection. It sequences flash programming and holds the core while programming is in progress.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: read-return owner and flash-programming phase.
package mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DATA,
    OWN_FETCH
  } mem_owner_t;

  typedef enum logic [1:0] {
    PH_RUN,
    PH_LOAD,
    PH_DRAIN
  } arb_phase_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: flash loader > data > fetch, with fetch starvation protection
// and a core hold while flash programming is in progress.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flash_en,
  input  logic [WIDTH-1:0]      flash_addr,
  input  logic [WIDTH-1:0]      flash_data,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [WIDTH-1:0]      data_addr,
  input  logic [WIDTH-1:0]      data_wdata,
  output logic                  data_gnt,
  output logic                  data_rvalid,
  input  logic                  fetch_req,
  input  logic [WIDTH-1:0]      fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  core_hold,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata
);

  localparam int unsigned cnt_w = $clog2(STARVE_LIMIT + 1);

  arb_phase_t       phase, phase_next;
  mem_owner_t       owner, owner_next;
  logic [cnt_w-1:0] starve_cnt, starve_next;
  logic             starved;

  // Byte offset and upper bits are intentionally dropped: addresses wrap modulo RAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{flash_addr[1:0], flash_addr[WIDTH-1:ADDR_WIDTH+2],
                              data_addr[1:0], data_addr[WIDTH-1:ADDR_WIDTH+2],
                              fetch_addr[1:0], fetch_addr[WIDTH-1:ADDR_WIDTH+2]};

  always_comb begin
    core_hold = flash_en || (phase != PH_RUN);
    starved   = (starve_cnt == cnt_w'(STARVE_LIMIT));
    data_gnt  = 1'b0;
    fetch_gnt = 1'b0;
    if (!core_hold) begin
      if (data_req && !(starved && fetch_req)) begin
        data_gnt = 1'b1;
      end else if (fetch_req) begin
        fetch_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (flash_en) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = flash_addr[ADDR_WIDTH+1:2];
      ram_wdata = flash_data;
    end else if (data_gnt) begin
      ram_en    = 1'b1;
      ram_we    = data_we;
      ram_addr  = data_addr[ADDR_WIDTH+1:2];
      ram_wdata = data_wdata;
    end else if (fetch_gnt) begin
      ram_en    = 1'b1;
      ram_addr  = fetch_addr[ADDR_WIDTH+1:2];
    end
  end

  always_comb begin
    owner_next = OWN_NONE;
    if (data_gnt && !data_we) begin
      owner_next = OWN_DATA;
    end else if (fetch_gnt) begin
      owner_next = OWN_FETCH;
    end
  end

  // Starvation count is frozen while the core is held so flash bursts don't skew it.
  always_comb begin
    starve_next = starve_cnt;
    if (!core_hold) begin
      if (fetch_req && !fetch_gnt) begin
        if (!starved) begin
          starve_next = starve_cnt + cnt_w'(1);
        end
      end else begin
        starve_next = '0;
      end
    end
  end

  always_comb begin
    phase_next = phase;
    unique case (phase)
      PH_RUN:   if (flash_en) phase_next = PH_LOAD;
      PH_LOAD:  if (!flash_en) phase_next = PH_DRAIN;
      PH_DRAIN: phase_next = flash_en ? PH_LOAD : PH_RUN;
      default:  phase_next = PH_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= PH_RUN;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      phase      <= phase_next;
      owner      <= owner_next;
      starve_cnt <= starve_next;
    end
  end

  assign data_rvalid  = (owner == OWN_DATA);
  assign fetch_rvalid = (owner == OWN_FETCH);
  assign rdata        = ram_rdata;

endmodule
